// File: rtl/blk_sched.sv
// Block scheduler: round-robin grants one of two byte sources a whole block.
// Each block is a header byte followed by BLKBYTES payload bytes, written to a FIFO.
module blk_sched #(
    parameter int BLOCKSIZE = 1024,
    parameter int FIFODEPTH = 2047
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        en,
    input  logic        src0Valid,
    input  logic        src1Valid,
    input  logic [7:0]  src0Data,
    input  logic [7:0]  src1Data,
    output logic        src0Rdy,
    output logic        src1Rdy,
    input  logic [10:0] wrcnt,
    output logic        fifoWr,
    output logic [7:0]  wdata,
    output logic        activeSrc,
    output logic        busy,
    output logic        blkDone
);

    localparam int BLKBYTES = BLOCKSIZE / 8;
    localparam int CW       = $clog2(BLKBYTES + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(BLKBYTES);
    localparam logic [CW-1:0] CNT_LAST = CW'(BLKBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_last;
    logic            r_active;
    logic            r_fifoWr;
    logic [7:0]      r_wdata;
    logic            r_blkDone;

    logic            w_space_ok;
    logic            w_req;
    logic            w_grant;
    logic            w_rdy;
    logic            w_acc;
    logic [7:0]      w_din;

    // Header plus full payload must fit; checked only before granting.
    assign w_space_ok = (32'(wrcnt) + 32'(BLKBYTES) + 32'd1) <= 32'(FIFODEPTH);
    assign w_req      = src0Valid | src1Valid;
    assign w_grant    = (src0Valid && src1Valid) ? ~r_last : src1Valid;

    assign w_rdy  = (r_state == S_DATA) && (r_cnt < CNT_FULL);
    assign w_acc  = r_active ? (src1Valid & w_rdy) : (src0Valid & w_rdy);
    assign w_din  = r_active ? src1Data : src0Data;

    assign src0Rdy   = w_rdy & ~r_active;
    assign src1Rdy   = w_rdy &  r_active;
    assign fifoWr    = r_fifoWr;
    assign wdata     = r_wdata;
    assign activeSrc = r_active;
    assign busy      = (r_state != S_IDLE);
    assign blkDone   = r_blkDone;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_last    <= 1'b1;
            r_active  <= 1'b0;
            r_fifoWr  <= 1'b0;
            r_wdata   <= '0;
            r_blkDone <= 1'b0;
        end else begin
            r_fifoWr  <= 1'b0;
            r_blkDone <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (en && w_req && w_space_ok) begin
                        r_active <= w_grant;
                        r_last   <= w_grant;
                        r_state  <= S_HDR;
                    end
                end
                S_HDR: begin
                    r_fifoWr <= 1'b1;
                    r_wdata  <= 8'hA0 | {7'd0, r_active};
                    r_cnt    <= '0;
                    r_state  <= S_DATA;
                end
                S_DATA: begin
                    if (w_acc) begin
                        r_fifoWr <= 1'b1;
                        r_wdata  <= w_din;
                        r_cnt    <= r_cnt + 1'b1;
                        if (r_cnt == CNT_LAST) begin
                            r_blkDone <= 1'b1;
                            r_state   <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
